rx_packet_framer: RTL
=====================

// Module: rx_packet_framer
// PURPOSE
//  Gen1/Gen2 receive-side packet framer: scans descrambled, 8b/10b-decoded symbols on LANES byte lanes, tracks
//  TLP/DLLP framing state across clock cycles and emits per-byte start/end/EDB/valid markers plus framing errors.
//  Sits between lane deskew and the data-link layer; replaces the stateless per-cycle identifier with LANES
//  parametrised, carry-over packet state, error detection and packet statistics.
// PARAMETERS
//  LANES     8   byte lanes per cycle (1,2,4,8,16,32,64); lane 0 = earliest symbol
//  CNT_W     16  width of statistics counters
// PORTS
//  clk           in   1         clock; all logic on rising edge
//  rst           in   1         synchronous reset, active-high
//  link_up       in   1         LTSSM in L0; 0 forces framer idle
//  active_lanes  in   7         lanes in use (1..LANES, power of two); lanes >= active_lanes ignored
//  valid_in      in   1         data_in/dk_in carry symbols this cycle
//  data_in       in   8*LANES   symbol bytes, lane i = [8i+7:8i]
//  dk_in         in   LANES     1 = lane byte is a K-symbol
//  data_out      out  8*LANES   data_in delayed one cycle
//  pl_valid      out  LANES     byte is packet payload (inside STP..END or SDP..END, framing symbols excluded)
//  pl_tlpstart   out  LANES     lane carried STP
//  pl_tlpend     out  LANES     lane carried END closing a TLP
//  pl_tlpedb     out  LANES     lane carried EDB (nullified TLP)
//  pl_dlpstart   out  LANES     lane carried SDP
//  pl_dlpend     out  LANES     lane carried END closing a DLLP
//  framing_err   out  1         pulse: framing violation found in this output cycle
//  tlp_count     out  CNT_W     TLPs closed by END (wraps)
//  dlp_count     out  CNT_W     DLLPs closed by END (wraps)
//  err_count     out  CNT_W     framing errors (saturates at all-ones)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Latency valid_in -> outputs: exactly 1 cycle, all outputs registered.
//  - K-codes: STP 0xFB, SDP 0x5C, END 0xFD, EDB 0xFE; COM/SKP/IDL/PAD are filler (no state effect outside packet).
//  - State IDLE/IN_TLP/IN_DLP; evaluated byte-serially lane 0..active_lanes-1 within a cycle, final state registered.
//  - IDLE: STP->IN_TLP, SDP->IN_DLP; END/EDB -> error, stay IDLE; D-symbols ignored (pl_valid=0).
//  - IN_TLP: D-symbol -> pl_valid; END -> tlpend, IDLE, tlp_count+1; EDB -> tlpedb, IDLE, no count.
//  - IN_DLP: D-symbol -> pl_valid; END -> dlpend, IDLE, dlp_count+1; EDB -> error, IDLE.
//  - In packet, STP/SDP: error, abandon current packet, start new one on that lane. Other K-symbol: error, IDLE.
//  - Several errors in one cycle: framing_err=1, err_count += 1 (once per cycle).
//  - Packets may start/end on any lane and span any number of cycles; several packets per cycle allowed.
//  - valid_in=0: marker outputs 0, state and counters held, data_out still updates.
//  - link_up=0: state forced IDLE next cycle, markers 0, counters held; mid-packet drop raises no error.
//  - Inactive lanes: output markers 0, data_out passes through. active_lanes changes only while link_up=0.
//  - rst mid-packet: state IDLE, counters 0 on next edge; subsequent END before STP/SDP is an error.
// CONFIGURATION
//  RX_FRAMER_DLLP_LEN_CHECK_EN defined: 3-bit DLLP byte counter; END with count != 6, or 7th payload byte, -> error,
//  no dlpend, dlp_count unchanged, state IDLE. Undefined: no counter, any DLLP length accepted.
// STRUCTURE
//  rx_framer_pkg: K-code constants, framer_state_t enum (IDLE/IN_TLP/IN_DLP), symbol class enum
//  (DATA/STP/SDP/END/EDB/FILLER/BAD_K).
//  Sub-module rx_framer_sym_class: combinational per-lane classifier (byte+K -> class), LANES instances; the
//  byte-serial state chain and registers stay in rx_packet_framer.
// TESTING
//  LANES=8, all active: STP on lane 2, D on 3..7, next cycle D 0..5, END lane 6 -> tlpstart=0x04, valid 0xF8 then
//   0x3F, tlpend=0x40, tlp_count=1.
//  SDP lane 0, 6 D bytes, END lane 7 -> dlpstart=0x01, valid=0x7E, dlpend=0x80, dlp_count=1, no error.
//  END lane 0 while IDLE -> framing_err=1, err_count=1, no tlpend/dlpend.
//  STP lane 1, D, EDB lane 4 -> tlpedb=0x10, tlp_count unchanged; then STP+D+STP -> framing_err, 2nd STP restarts.
//  active_lanes=4, STP on lane 5 -> ignored: all markers 0; link_up 0 mid-TLP -> IDLE, no error.
//  With RX_FRAMER_DLLP_LEN_CHECK_EN: SDP + 4 D + END -> framing_err=1, dlp_count unchanged; without: dlp_count+1.

Source files
------------

// File: rtl/rx_framer_pkg.sv
// Shared definitions for the receive packet framer: K-code values, framer state and symbol classes.
package rx_framer_pkg;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_PAD = 8'hF7;

    typedef enum logic [1:0] {
        IDLE,
        IN_TLP,
        IN_DLP
    } framer_state_t;

    typedef enum logic [2:0] {
        SYM_DATA,
        SYM_STP,
        SYM_SDP,
        SYM_END,
        SYM_EDB,
        SYM_FILLER,
        SYM_BAD_K
    } sym_class_t;

endpackage

// File: rtl/rx_framer_sym_class.sv
// Combinational classifier for one lane: decoded byte plus K flag -> symbol class.
module rx_framer_sym_class
    import rx_framer_pkg::*;
(
    input  logic [7:0] sym,
    input  logic       is_k,
    output sym_class_t sym_class
);

    always_comb begin
        sym_class = SYM_DATA;
        if (is_k) begin
            case (sym)
                K_STP:                      sym_class = SYM_STP;
                K_SDP:                      sym_class = SYM_SDP;
                K_END:                      sym_class = SYM_END;
                K_EDB:                      sym_class = SYM_EDB;
                K_COM, K_SKP, K_IDL, K_PAD: sym_class = SYM_FILLER;
                default:                    sym_class = SYM_BAD_K;
            endcase
        end
    end

endmodule

// File: rtl/rx_packet_framer.sv
// Receive packet framer: byte-serial TLP/DLLP framing across LANES lanes with carry-over state and statistics.
// Optional DLLP length check enabled by defining RX_FRAMER_DLLP_LEN_CHECK_EN.
module rx_packet_framer
    import rx_framer_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic [6:0]           active_lanes,
    input  logic                 valid_in,
    input  logic [8*LANES-1:0]   data_in,
    input  logic [LANES-1:0]     dk_in,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     pl_valid,
    output logic [LANES-1:0]     pl_tlpstart,
    output logic [LANES-1:0]     pl_tlpend,
    output logic [LANES-1:0]     pl_tlpedb,
    output logic [LANES-1:0]     pl_dlpstart,
    output logic [LANES-1:0]     pl_dlpend,
    output logic                 framing_err,
    output logic [CNT_W-1:0]     tlp_count,
    output logic [CNT_W-1:0]     dlp_count,
    output logic [CNT_W-1:0]     err_count
);

    sym_class_t lane_class [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_cls
        rx_framer_sym_class u_cls (
            .sym       (data_in[8*g +: 8]),
            .is_k      (dk_in[g]),
            .sym_class (lane_class[g])
        );
    end

    framer_state_t    state_q, state_d;
    logic [LANES-1:0] valid_d, tstart_d, tend_d, tedb_d, dstart_d, dend_d;
    logic             err_d;
    logic [CNT_W-1:0] tlp_inc, dlp_inc;
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
    localparam logic [2:0] DLLP_LEN = 3'd6;
    logic [2:0] dlen_q, dlen_d;
`endif

    // state_d is the running state as lanes are consumed in order; its last value is registered.
    always_comb begin
        state_d  = state_q;
        valid_d  = '0;
        tstart_d = '0;
        tend_d   = '0;
        tedb_d   = '0;
        dstart_d = '0;
        dend_d   = '0;
        err_d    = 1'b0;
        tlp_inc  = '0;
        dlp_inc  = '0;
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
        dlen_d   = dlen_q;
`endif
        if (!link_up) begin
            state_d = IDLE;
        end else if (valid_in) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < int'(active_lanes)) begin
                    case (lane_class[i])
                        SYM_STP: begin
                            err_d       = err_d | (state_d != IDLE);
                            tstart_d[i] = 1'b1;
                            state_d     = IN_TLP;
                        end
                        SYM_SDP: begin
                            err_d       = err_d | (state_d != IDLE);
                            dstart_d[i] = 1'b1;
                            state_d     = IN_DLP;
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
                            dlen_d      = 3'd0;
`endif
                        end
                        SYM_DATA: begin
                            if (state_d == IN_TLP) begin
                                valid_d[i] = 1'b1;
                            end else if (state_d == IN_DLP) begin
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
                                if (dlen_d == DLLP_LEN) begin
                                    err_d   = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    valid_d[i] = 1'b1;
                                    dlen_d     = dlen_d + 3'd1;
                                end
`else
                                valid_d[i] = 1'b1;
`endif
                            end
                        end
                        SYM_END: begin
                            if (state_d == IN_TLP) begin
                                tend_d[i] = 1'b1;
                                tlp_inc   = tlp_inc + CNT_W'(1);
                            end else if (state_d == IN_DLP) begin
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
                                if (dlen_d == DLLP_LEN) begin
                                    dend_d[i] = 1'b1;
                                    dlp_inc   = dlp_inc + CNT_W'(1);
                                end else begin
                                    err_d = 1'b1;
                                end
`else
                                dend_d[i] = 1'b1;
                                dlp_inc   = dlp_inc + CNT_W'(1);
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                            state_d = IDLE;
                        end
                        SYM_EDB: begin
                            if (state_d == IN_TLP) tedb_d[i] = 1'b1;
                            else                   err_d     = 1'b1;
                            state_d = IDLE;
                        end
                        default: begin
                            // Filler and unknown K-codes only matter when they interrupt a packet.
                            if (state_d != IDLE) begin
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_out    <= '0;
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpstart <= '0;
            pl_dlpend   <= '0;
            framing_err <= 1'b0;
            tlp_count   <= '0;
            dlp_count   <= '0;
            err_count   <= '0;
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
            dlen_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_out    <= data_in;
            pl_valid    <= valid_d;
            pl_tlpstart <= tstart_d;
            pl_tlpend   <= tend_d;
            pl_tlpedb   <= tedb_d;
            pl_dlpstart <= dstart_d;
            pl_dlpend   <= dend_d;
            framing_err <= err_d;
            tlp_count   <= tlp_count + tlp_inc;
            dlp_count   <= dlp_count + dlp_inc;
            if (err_d && (err_count != '1)) err_count <= err_count + CNT_W'(1);
`ifdef RX_FRAMER_DLLP_LEN_CHECK_EN
            dlen_q      <= dlen_d;
`endif
        end
    end

endmodule
